// File: rtl/addr_range_sched_if.sv
// addr_range_sched_if: requester, host-config, comparator and status signals of the
// address-range scheduler, bundled into one interface.
// slave  = the scheduler's view of the bundle.
// master = the environment's view (requesters, host and comparator).
interface addr_range_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int CFG_WIDTH  = 10,
    parameter int FLAG_WIDTH = 32
);
    // lookup requesters
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0][63:0]    req_addr;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic                        rsp_hit;
    logic [FLAG_WIDTH-1:0]       rsp_flags;
    // host rule writes
    logic                        host_cfg_valid;
    logic                        host_cfg_ready;
    logic [CFG_WIDTH-1:0]        host_cfg_address;
    logic [63:0]                 host_cfg_writedata;
    logic [7:0]                  host_cfg_byteenable;
    // comparator lookup and config ports
    logic                        cmp_rx_valid;
    logic [63:0]                 cmp_rx_addr;
    logic                        cmp_tx_valid;
    logic [FLAG_WIDTH-1:0]       cmp_tx_flags;
    logic [CFG_WIDTH-1:0]        cmp_cfg_address;
    logic                        cmp_cfg_write;
    logic [63:0]                 cmp_cfg_writedata;
    logic [7:0]                  cmp_cfg_byteenable;
    // status
    logic                        busy;
    logic [31:0]                 miss_count;

    modport slave (
        input  req_valid, req_addr,
        input  host_cfg_valid, host_cfg_address, host_cfg_writedata, host_cfg_byteenable,
        input  cmp_tx_valid, cmp_tx_flags,
        output req_ready, rsp_valid, rsp_hit, rsp_flags,
        output host_cfg_ready,
        output cmp_rx_valid, cmp_rx_addr,
        output cmp_cfg_address, cmp_cfg_write, cmp_cfg_writedata, cmp_cfg_byteenable,
        output busy, miss_count
    );

    modport master (
        output req_valid, req_addr,
        output host_cfg_valid, host_cfg_address, host_cfg_writedata, host_cfg_byteenable,
        output cmp_tx_valid, cmp_tx_flags,
        input  req_ready, rsp_valid, rsp_hit, rsp_flags,
        input  host_cfg_ready,
        input  cmp_rx_valid, cmp_rx_addr,
        input  cmp_cfg_address, cmp_cfg_write, cmp_cfg_writedata, cmp_cfg_byteenable,
        input  busy, miss_count
    );
endinterface

// File: rtl/addr_range_sched.sv
// addr_range_sched: round-robin lookup scheduler and rule-write sequencer in front of
// the address-range comparator. Host rule writes wait for in-flight lookups to drain,
// are applied in a single cycle, and are then followed by a settle gap before lookups
// resume. Responses are routed back to their requester by a tag carried alongside the
// comparator latency.
// Optional feature: define ADDR_RANGE_SCHED_MISS_CNT_EN to enable the saturating
// miss counter. Without it, miss_count reads as zero.

// Per-requester response strobe: fires when the tag leaving the latency pipe is ours.
module addr_range_sched_lane #(
    parameter int TAG_W = 2,
    parameter int LANE  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_vld,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_rsp_valid
);
    logic w_mine;
    logic r_rsp_valid;

    assign w_mine = i_vld && (i_tag == TAG_W'(LANE));

    // one-cycle registered response strobe for this requester
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rsp_valid <= 1'b0;
        else          r_rsp_valid <= w_mine;
    end

    assign o_rsp_valid = r_rsp_valid;
endmodule

module addr_range_sched #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_REQ_LOG2 = 2,
    parameter int CFG_WIDTH    = 10,
    parameter int FLAG_WIDTH   = 32,
    parameter int LOOKUP_LAT   = 3,
    parameter int SETTLE_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    addr_range_sched_if.slave    bus
);
    // inflight never exceeds LOOKUP_LAT+2; leave headroom up to LOOKUP_LAT+3
    localparam int IFW = $clog2(LOOKUP_LAT + 4);
    localparam logic [NUM_REQ_LOG2-1:0] LAST_IDX = NUM_REQ_LOG2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_WRITE  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [3:0]                             r_settle_cnt;
    logic [NUM_REQ_LOG2-1:0]                r_rr_ptr;
    logic [IFW-1:0]                         r_inflight;

    // arbitration
    logic [NUM_REQ-1:0]                     w_grant;
    logic                                   w_grant_any;
    logic [NUM_REQ_LOG2-1:0]                w_grant_idx;
    logic [NUM_REQ_LOG2-1:0]                w_cand;
    int                                     w_sum;

    // issue + latency pipe; stage 0 is the cycle the lookup is on cmp_rx
    logic [LOOKUP_LAT:0]                    r_vld_pipe;
    logic [LOOKUP_LAT:0][NUM_REQ_LOG2-1:0]  r_tag_pipe;
    logic [63:0]                            r_cmp_rx_addr;
    logic                                   w_pipe_out;
    logic [NUM_REQ_LOG2-1:0]                w_pipe_tag;

    // response
    logic [NUM_REQ-1:0]                     w_rsp_valid;
    logic                                   r_rsp_hit;
    logic [FLAG_WIDTH-1:0]                  r_rsp_flags;

    // comparator config port
    logic                                   r_cfg_write;
    logic [CFG_WIDTH-1:0]                   r_cfg_address;
    logic [63:0]                            r_cfg_writedata;
    logic [7:0]                             r_cfg_byteenable;

    // ------------------------------------------------------------------
    // sequencer FSM
    // ------------------------------------------------------------------

    // state register and settle counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_RUN;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WRITE)
                r_settle_cnt <= 4'(SETTLE_CYC);
            else if (r_state == S_SETTLE)
                r_settle_cnt <= r_settle_cnt - 4'd1;
        end
    end

    // next state: a pending host write always wins over new lookups
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (bus.host_cfg_valid)   w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_inflight == '0)     w_state_nxt = S_WRITE;
            S_WRITE:                            w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle_cnt == 4'd1) w_state_nxt = S_RUN;
            default:                            w_state_nxt = S_RUN;
        endcase
    end

    assign bus.busy           = (r_state != S_RUN);
    assign bus.host_cfg_ready = (r_state == S_WRITE);

    // ------------------------------------------------------------------
    // round-robin arbiter; grants only in RUN with no host write waiting
    // ------------------------------------------------------------------

    // scan requesters starting at rr_ptr, first valid one wins
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_sum       = 0;
        if (r_state == S_RUN && !bus.host_cfg_valid) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum = int'(r_rr_ptr) + k;
                if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
                w_cand = NUM_REQ_LOG2'(w_sum);
                if (!w_grant_any && bus.req_valid[w_cand]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
            if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = w_grant;

    // pointer moves past the winner; holds when nobody is granted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rr_ptr <= '0;
        else if (w_grant_any)
            r_rr_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
    end

    // ------------------------------------------------------------------
    // issue and tag pipe
    // ------------------------------------------------------------------

    // register the winning address onto the comparator lookup port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cmp_rx_addr <= '0;
        else if (w_grant_any)
            r_cmp_rx_addr <= bus.req_addr[w_grant_idx];
    end

    // valid/tag shift register tracking the comparator latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[LOOKUP_LAT-1:0], w_grant_any};
            r_tag_pipe <= {r_tag_pipe[LOOKUP_LAT-1:0], w_grant_idx};
        end
    end

    assign bus.cmp_rx_valid = r_vld_pipe[0];
    assign bus.cmp_rx_addr  = r_cmp_rx_addr;
    assign w_pipe_out       = r_vld_pipe[LOOKUP_LAT];
    assign w_pipe_tag       = r_tag_pipe[LOOKUP_LAT];

    // ------------------------------------------------------------------
    // response routing
    // ------------------------------------------------------------------

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        addr_range_sched_lane #(
            .TAG_W (NUM_REQ_LOG2),
            .LANE  (g)
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_vld       (w_pipe_out),
            .i_tag       (w_pipe_tag),
            .o_rsp_valid (w_rsp_valid[g])
        );
    end

    // shared hit/flags payload, zero whenever no response is presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_hit   <= 1'b0;
            r_rsp_flags <= '0;
        end else if (w_pipe_out) begin
            r_rsp_hit   <= bus.cmp_tx_valid;
            r_rsp_flags <= bus.cmp_tx_flags;
        end else begin
            r_rsp_hit   <= 1'b0;
            r_rsp_flags <= '0;
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_flags = r_rsp_flags;

    // outstanding lookups: granted but not yet answered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_inflight <= '0;
        else begin
            case ({w_grant_any, |w_rsp_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // comparator rule-write port
    // ------------------------------------------------------------------

    // capture host fields on entry to WRITE so the pulse and data align
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_write      <= 1'b0;
            r_cfg_address    <= '0;
            r_cfg_writedata  <= '0;
            r_cfg_byteenable <= '0;
        end else begin
            r_cfg_write <= (w_state_nxt == S_WRITE);
            if (w_state_nxt == S_WRITE) begin
                r_cfg_address    <= bus.host_cfg_address;
                r_cfg_writedata  <= bus.host_cfg_writedata;
                r_cfg_byteenable <= bus.host_cfg_byteenable;
            end
        end
    end

    assign bus.cmp_cfg_write      = r_cfg_write;
    assign bus.cmp_cfg_address    = r_cfg_address;
    assign bus.cmp_cfg_writedata  = r_cfg_writedata;
    assign bus.cmp_cfg_byteenable = r_cfg_byteenable;

    // ------------------------------------------------------------------
    // miss counter
    // ------------------------------------------------------------------
`ifdef ADDR_RANGE_SCHED_MISS_CNT_EN
    logic [31:0] r_miss_cnt;

    // count responses without a hit, counted as they are sampled; saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_miss_cnt <= '0;
        else if (w_pipe_out && !bus.cmp_tx_valid && (r_miss_cnt != 32'hFFFF_FFFF))
            r_miss_cnt <= r_miss_cnt + 32'd1;
    end

    assign bus.miss_count = r_miss_cnt;
`else
    assign bus.miss_count = '0;
`endif

endmodule

// File: doc/addr_range_sched.md
# addr_range_sched

Scheduler and configuration sequencer in front of the address-range comparator. Round-robin arbitrates up to NUM_REQ requesters onto the comparator's single lookup port and routes each result back to its originator by tag. Owns the comparator's rule-table write port: host rule writes are held off until in-flight lookups drain, then applied, then allowed to settle, so no lookup ever sees a partially updated rule.

## Interface
- NUM_REQ, 4, number of lookup requesters (2..8)
- NUM_REQ_LOG2, 2, log2 of NUM_REQ
- CFG_WIDTH, 10, rule-table word address width
- FLAG_WIDTH, 32, flag vector width
- LOOKUP_LAT, 3, cycles from cmp_rx_valid to valid cmp_tx_valid/cmp_tx_flags
- SETTLE_CYC, 2, idle cycles after a rule write before lookups resume (1..15)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester lookup request
- req_addr  in  64*NUM_REQ  requester i address at [64*i+63:64*i]
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_hit  out  1  any rule matched
- rsp_flags  out  FLAG_WIDTH  OR of matching rules' flags
- host_cfg_valid  in  1  rule write request, held until accepted
- host_cfg_ready  out  1  write accepted this cycle
- host_cfg_address  in  CFG_WIDTH  rule word address
- host_cfg_writedata  in  64  write data
- host_cfg_byteenable  in  8  byte enables
- cmp_rx_valid  out  1  lookup issue to comparator
- cmp_rx_addr  out  64  lookup address
- cmp_tx_valid  in  1  comparator hit
- cmp_tx_flags  in  FLAG_WIDTH  comparator flags
- cmp_cfg_address / cmp_cfg_write / cmp_cfg_writedata / cmp_cfg_byteenable  out  CFG_WIDTH/1/64/8  comparator config port
- busy  out  1  state != RUN
- miss_count  out  32  see Configuration

## Operation
- States: RUN, DRAIN, WRITE, SETTLE. Reset state RUN.
- RUN: if host_cfg_valid, no grant this cycle, next DRAIN. Else grant one requester with req_valid, round-robin starting at rr_ptr; rr_ptr <= granted+1 mod NUM_REQ. rr_ptr unchanged with no grant.
- DRAIN: no grants; when inflight==0 -> WRITE (same-cycle check, so DRAIN lasts ≥1 cycle).
- WRITE: exactly one cycle; cmp_cfg_write=1 with host fields registered into cmp_cfg_*; host_cfg_ready=1; -> SETTLE, load settle counter with SETTLE_CYC.
- SETTLE: counter decrements; at 1 -> RUN. No grants.
- req_ready is combinational from state, host_cfg_valid, req_valid, rr_ptr; never depends on req_ready of others.
- Issue: accepted request registered to cmp_rx_valid/cmp_rx_addr next cycle; tag (requester index) pushed into a LOOKUP_LAT-deep valid/tag shift register.
- Response: when shift-register output valid, rsp_valid[tag]=1, rsp_hit=cmp_tx_valid, rsp_flags=cmp_tx_flags (registered, one cycle after sampling).
- inflight counter: +1 on grant, −1 on rsp_valid; width covers LOOKUP_LAT+3; simultaneous inc/dec holds value.
- Back-to-back host writes each pass through full DRAIN/WRITE/SETTLE.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_hit 0, rsp_flags 0, host_cfg_ready 0, cmp_rx_valid 0, cmp_rx_addr 0, cmp_cfg_* 0, busy 0, miss_count 0, rr_ptr 0, inflight 0, shift register cleared.
- Request handshake at cycle T -> cmp_rx_valid at T+1 -> sample at T+1+LOOKUP_LAT -> rsp_valid at T+2+LOOKUP_LAT. Throughput one lookup per cycle in RUN.
- host_cfg_valid rising at T with no traffic: DRAIN T+1, WRITE T+2 (host_cfg_ready high), SETTLE T+3..T+2+SETTLE_CYC, first grant T+3+SETTLE_CYC.
- Reset mid-operation discards in-flight lookups; no rsp_valid for them after reset release; pending host write not applied.

## Configuration
- ADDR_RANGE_SCHED_MISS_CNT_EN defined: miss_count increments by 1 on each response with rsp_hit=0, saturates at 0xFFFF_FFFF, cleared only by reset.
- Not defined: miss_count tied to 0, no counter logic.

## Test plan
- Single requester 0, addr 0x1000, cmp_tx_valid=1, flags 0x5 -> rsp_valid=0001, rsp_hit=1, rsp_flags=0x5 exactly 2+LOOKUP_LAT cycles after handshake.
- All four requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses return in same order with matching tags.
- Host write addr 0x40, data 0xDEAD_BEEF, be 0xFF while 3 lookups in flight -> no grant until inflight=0; single cmp_cfg_write pulse; first grant exactly SETTLE_CYC+1 cycles after write.
- host_cfg_valid and req_valid same cycle -> no grant; write applied first; requests served afterwards from unchanged rr_ptr.
- Assert reset_n low with 2 lookups in flight and state SETTLE -> all outputs at reset values immediately; no stray rsp_valid after release.
- With ADDR_RANGE_SCHED_MISS_CNT_EN: 5 misses, 3 hits -> miss_count=5; without macro -> miss_count=0.
